fifo_drain: RTL and testbench

FIFO_DRAIN -- requirements
Module: fifo_drain

---
 rtl/fifo_drain.sv | 116 +++++++++++
 tb/tb_fifo_drain.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain.sv
// fifo_drain: drains a 1-cycle-read-latency fifo into a registered valid/ready port; FIFO_DRAIN_STATS_EN adds o_xfer_cnt.
// Latency 2 cycles read-to-present; i_ready low holds o_data and reads stop once 2 words are owned.
module fifo_drain #(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_fifo_empty,
  output logic             o_fifo_rd_en,
  input  logic [DATAW-1:0] i_fifo_rd_data,
  output logic             o_valid,
  output logic [DATAW-1:0] o_data,
  input  logic             i_ready
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [15:0]      o_xfer_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             inflight;
  logic [DATAW-1:0] entry0;
  logic [DATAW-1:0] entry1;
  logic [DATAW-1:0] entry0_nxt;
  logic [DATAW-1:0] entry1_nxt;
  logic             pop;
  logic             capture;
  logic [1:0]       count;
  logic [2:0]       owned;

  assign pop     = o_valid & i_ready;
  assign capture = inflight;

  always_comb begin
    count = 2'd0;
    case (state)
      ONE:     count = 2'd1;
      TWO:     count = 2'd2;
      default: count = 2'd0;
    endcase
  end

  // Words already committed to the buffer, including the one still in flight.
  assign owned        = {1'b0, count} + {2'b00, inflight};
  assign o_fifo_rd_en = rst_n & ~i_fifo_empty & (owned < (3'd2 + {2'b00, pop}));

  always_comb begin
    state_nxt  = state;
    entry0_nxt = entry0;
    entry1_nxt = entry1;
    case (state)
      EMPTY: begin
        if (capture) begin
          state_nxt  = ONE;
          entry0_nxt = i_fifo_rd_data;
        end
      end
      ONE: begin
        if (capture && pop) begin
          entry0_nxt = i_fifo_rd_data;
        end else if (capture) begin
          state_nxt  = TWO;
          entry1_nxt = i_fifo_rd_data;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          entry0_nxt = entry1;
          if (capture) begin
            entry1_nxt = i_fifo_rd_data;
          end else begin
            state_nxt = ONE;
          end
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      inflight <= 1'b0;
      entry0   <= '0;
      entry1   <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= o_fifo_rd_en;
      entry0   <= entry0_nxt;
      entry1   <= entry1_nxt;
    end
  end

  assign o_valid = (state != EMPTY);
  assign o_data  = entry0;

`ifdef FIFO_DRAIN_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_xfer_cnt <= 16'd0;
    end else if (pop) begin
      o_xfer_cnt <= o_xfer_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: queue-based upstream fifo and in-order scoreboard, directed scenarios then random stress.
module tb_fifo_drain;
  localparam int DATAW = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_fifo_empty = 1'b1;
  logic             o_fifo_rd_en;
  logic [DATAW-1:0] i_fifo_rd_data = '0;
  logic             o_valid;
  logic [DATAW-1:0] o_data;
  logic             i_ready = 1'b0;
`ifdef FIFO_DRAIN_STATS_EN
  logic [15:0]      o_xfer_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int cyc = 0;
  int tot_rd = 0;
  int tot_pop = 0;
  bit last_rd;
  bit last_pop;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  int win_rd, win_rd_first, win_rd_last;
  int win_pop, win_pop_first, win_pop_last;

  always #5 clk = ~clk;

  fifo_drain #(.DATAW(DATAW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_fifo_empty   (i_fifo_empty),
    .o_fifo_rd_en   (o_fifo_rd_en),
    .i_fifo_rd_data (i_fifo_rd_data),
    .o_valid        (o_valid),
    .o_data         (o_data),
    .i_ready        (i_ready)
`ifdef FIFO_DRAIN_STATS_EN
    ,
    .o_xfer_cnt     (o_xfer_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  task automatic push(input logic [7:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    i_fifo_empty = 1'b0;
  endtask

  // One clock: sample at negedge, then advance the upstream fifo model after posedge.
  task automatic cycle();
    logic [7:0] want;
    @(negedge clk);
    last_rd  = o_fifo_rd_en;
    last_pop = o_valid & i_ready;
    check("rd_while_empty", 32'(o_fifo_rd_en & i_fifo_empty), 32'd0);
    check("owned_le_2", 32'(tot_rd - tot_pop <= 2), 32'd1);
    if (prev_stall) begin
      check("stall_valid", 32'(o_valid), 32'd1);
      check("stall_hold", 32'(o_data), 32'(prev_data));
    end
    if (last_pop) begin
      if (exp_q.size() == 0) begin
        check("spurious_word", 32'(o_valid), 32'd0);
      end else begin
        want = exp_q.pop_front();
        check("word_order", 32'(o_data), 32'(want));
      end
    end
    prev_stall = o_valid & ~i_ready;
    prev_data  = o_data;
    if (last_rd)  tot_rd++;
    if (last_pop) tot_pop++;
    @(posedge clk);
    #1;
    if (last_rd && fq.size() > 0) i_fifo_rd_data = fq.pop_front();
    i_fifo_empty = (fq.size() == 0);
    cyc++;
  endtask

  task automatic run(input int n);
    win_rd = 0; win_rd_first = -1; win_rd_last = -1;
    win_pop = 0; win_pop_first = -1; win_pop_last = -1;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (last_rd) begin
        if (win_rd_first < 0) win_rd_first = cyc;
        win_rd_last = cyc;
        win_rd++;
      end
      if (last_pop) begin
        if (win_pop_first < 0) win_pop_first = cyc;
        win_pop_last = cyc;
        win_pop++;
      end
    end
  endtask

  // Called just after a posedge; leaves rst_n released just after the next posedge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_rd_en", 32'(o_fifo_rd_en), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
`ifdef FIFO_DRAIN_STATS_EN
    check("rst_xfer_cnt", 32'(o_xfer_cnt), 32'd0);
`endif
    fq.delete();
    exp_q.delete();
    i_fifo_empty   = 1'b1;
    i_fifo_rd_data = '0;
    prev_stall     = 1'b0;
    tot_rd         = 0;
    tot_pop        = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int start;
    int sent;
    int budget;

    do_reset();

    // Streaming: eight words, consumer always ready.
    i_ready = 1'b1;
    for (int w = 1; w <= 8; w++) push(8'(w));
    start = cyc + 1;
    run(14);
    check("stream_rd_cnt", 32'(win_rd), 32'd8);
    check("stream_rd_first", 32'(win_rd_first), 32'(start));
    check("stream_rd_span", 32'(win_rd_last - win_rd_first), 32'd7);
    check("stream_pop_cnt", 32'(win_pop), 32'd8);
    check("stream_pop_span", 32'(win_pop_last - win_pop_first), 32'd7);
    check("stream_latency", 32'(win_pop_first - win_rd_first), 32'd2);
    check("stream_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: five words queued, consumer stalled.
    i_ready = 1'b0;
    for (int w = 0; w < 5; w++) push(8'(8'h30 + w));
    run(10);
    check("bp_rd_cnt", 32'(win_rd), 32'd2);
    check("bp_valid", 32'(o_valid), 32'd1);
    check("bp_head", 32'(o_data), 32'h30);
    i_ready = 1'b1;
    run(12);
    check("bp_pop_cnt", 32'(win_pop), 32'd5);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Empty boundary: a single word into an empty fifo.
    run(3);
    push(8'hA5);
    run(6);
    check("single_rd_cnt", 32'(win_rd), 32'd1);
    check("single_pop_cnt", 32'(win_pop), 32'd1);
    check("single_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-stream with both entries full and the fifo still non-empty.
    i_ready = 1'b0;
    for (int w = 0; w < 4; w++) push(8'(8'h40 + w));
    run(6);
    check("full_valid", 32'(o_valid), 32'd1);
    check("full_owned", 32'(tot_rd - tot_pop), 32'd2);
    do_reset();
    push(8'h11);
    i_ready = 1'b1;
    start = cyc + 1;
    run(6);
    check("post_rst_rd_first", 32'(win_rd_first), 32'(start));
    check("post_rst_latency", 32'(win_pop_first - win_rd_first), 32'd2);
    check("post_rst_pop_cnt", 32'(win_pop), 32'd1);
    check("post_rst_drained", 32'(exp_q.size()), 32'd0);

    // Random stress: 1000 words, random arrivals and random consumer stalls.
    @(posedge clk);
    #1;
    do_reset();
    sent   = 0;
    budget = 20000;
    while ((sent < 1000 || exp_q.size() != 0) && budget > 0) begin
      i_ready = ($urandom_range(0, 3) != 0);
      if (sent < 1000 && $urandom_range(0, 1) == 1) begin
        push(8'($urandom_range(0, 255)));
        sent++;
      end
      cycle();
      budget--;
    end
    check("rand_budget_left", 32'(budget > 0), 32'd1);
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_pop_cnt", 32'(tot_pop), 32'd1000);
`ifdef FIFO_DRAIN_STATS_EN
    check("rand_xfer_cnt", 32'(o_xfer_cnt), 32'd1000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
